vga_line_fetch: RTL and testbench

//  Pixel-data stage directly downstream of the screen-position generator.

---
 rtl/vga_line_fetch.sv | 182 ++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : vga_line_fetch
//  Purpose  : Prefetches the next display line from framebuffer memory into a
//             ping-pong line buffer and emits RGB with 2-cycle-aligned syncs.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_line_fetch #(
    parameter int                H_PIX   = 640,
    parameter int                V_LINES = 480,
    parameter int                PIX_W   = 24,
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic [11:0]       sx,
    input  logic [11:0]       sy,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [PIX_W-1:0]  rsp_data,
    output logic [PIX_W-1:0]  rgb,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_de,
    output logic              underrun,
    output logic              underrun_stk
);

    localparam int              c_cnt_w     = $clog2(H_PIX + 1);
    localparam int              c_idx_w     = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam logic [c_cnt_w-1:0] c_h_last = c_cnt_w'(H_PIX - 1);
    localparam logic [c_cnt_w-1:0] c_h_pix  = c_cnt_w'(H_PIX);
    localparam logic [11:0]     c_h_pix_sx  = 12'(H_PIX);
    localparam logic [11:0]     c_v_lines   = 12'(V_LINES);
    localparam logic [11:0]     c_v_last    = 12'(V_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_i;
    logic [c_cnt_w-1:0]  r_w;
    logic                r_bank;
    logic [ADDR_W-1:0]   r_base;
    logic                r_underrun;
    logic                r_underrun_stk;

    logic                w_trig;
    logic [11:0]         w_target;
    logic [ADDR_W-1:0]   w_base;
    logic                w_start;
    logic                w_req_fire;
    logic                w_rsp_take;
    logic                w_underrun;

    logic [PIX_W-1:0]    r_line [2][H_PIX];

    logic                r_hs1;
    logic                r_vs1;
    logic                r_de1;
    logic [PIX_W-1:0]    r_pix1;
    logic                r_hs2;
    logic                r_vs2;
    logic                r_de2;
    logic [PIX_W-1:0]    r_rgb2;

    // Each visible line prefetches the following one; the last line wraps to line 0.
    assign w_trig     = (sx == 12'd0) && (sy < c_v_lines);
    assign w_target   = (sy == c_v_last) ? 12'd0 : sy + 12'd1;
    assign w_base     = FB_BASE + ADDR_W'(w_target) * ADDR_W'(H_PIX);
    assign w_req_fire = req_valid && req_ready;
    assign w_rsp_take = rsp_valid && (r_w < r_i);
    assign w_underrun = w_trig && (r_state != ST_IDLE);

    assign req_valid  = (r_state == ST_REQ);
    assign req_addr   = r_base + ADDR_W'(r_i);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = ST_REQ;
                    w_start     = 1'b1;
                end
            end
            ST_REQ: begin
                if (w_req_fire && (r_i == c_h_last)) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_w == c_h_pix) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_state        <= ST_IDLE;
            r_i            <= '0;
            r_w            <= '0;
            r_bank         <= 1'b0;
            r_base         <= '0;
            r_underrun     <= 1'b0;
            r_underrun_stk <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_underrun     <= w_underrun;
            r_underrun_stk <= r_underrun_stk | w_underrun;
            if (w_start) begin
                r_i    <= '0;
                r_w    <= '0;
                r_bank <= w_target[0];
                r_base <= w_base;
            end else begin
                if (w_req_fire) begin
                    r_i <= r_i + c_cnt_w'(1);
                end
                if (w_rsp_take) begin
                    r_w <= r_w + c_cnt_w'(1);
                end
            end
        end
    end

    // Buffer storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk_pix) begin
        if (w_rsp_take) begin
            r_line[r_bank][r_w[c_idx_w-1:0]] <= rsp_data;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (sx < c_h_pix_sx) begin
            r_pix1 <= r_line[sy[0]][sx[c_idx_w-1:0]];
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_de1  <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_de2  <= 1'b0;
            r_rgb2 <= '0;
        end else begin
            r_hs1  <= hsync;
            r_vs1  <= vsync;
            r_de1  <= de;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_de2  <= r_de1;
            r_rgb2 <= r_de1 ? r_pix1 : '0;
        end
    end

    assign rgb          = r_rgb2;
    assign out_hsync    = r_hs2;
    assign out_vsync    = r_vs2;
    assign out_de       = r_de2;
    assign underrun     = r_underrun;
    assign underrun_stk = r_underrun_stk;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_line_fetch
//  Purpose  : Scoreboard bench for vga_line_fetch with a 1-cycle-latency
//             memory whose data equals the requested address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_line_fetch;

    localparam int                H_PIX   = 8;
    localparam int                V_LINES = 4;
    localparam int                PIX_W   = 24;
    localparam int                ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] FB_BASE = 32'h100;
    localparam int                H_TOT   = 16;
    localparam int                V_TOT   = 6;

    logic              clk_pix = 1'b0;
    logic              rst_pix_n;
    logic [11:0]       sx;
    logic [11:0]       sy;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [PIX_W-1:0]  rsp_data;
    logic [PIX_W-1:0]  rgb;
    logic              out_hsync;
    logic              out_vsync;
    logic              out_de;
    logic              underrun;
    logic              underrun_stk;

    vga_line_fetch #(
        .H_PIX   (H_PIX),
        .V_LINES (V_LINES),
        .PIX_W   (PIX_W),
        .ADDR_W  (ADDR_W),
        .FB_BASE (FB_BASE)
    ) u_dut (
        .clk_pix      (clk_pix),
        .rst_pix_n    (rst_pix_n),
        .sx           (sx),
        .sy           (sy),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rgb          (rgb),
        .out_hsync    (out_hsync),
        .out_vsync    (out_vsync),
        .out_de       (out_de),
        .underrun     (underrun),
        .underrun_stk (underrun_stk)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic             hs;
        logic             vs;
        logic             de;
        logic             chk;
        logic [PIX_W-1:0] rgb;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                n_chk  = 0;
    int                n_pass = 0;
    int                n_acc  = 0;
    int                n_urun = 0;
    bit                mon_en = 0;
    bit                skip_trig = 0;
    bit                line_ok [V_LINES];
    bit                stall_prev = 0;
    logic [ADDR_W-1:0] stall_addr = '0;
    bit                m_acc;
    logic [ADDR_W-1:0] m_addr;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Drive one position-generator cycle and record what must come out of it.
    task automatic tick(input int x, input int y);
        exp_t e;
        int   t;
        @(posedge clk_pix);
        #1;
        sx    = 12'(x);
        sy    = 12'(y);
        de    = (x < H_PIX) && (y < V_LINES);
        hsync = !(x >= 10 && x < 12);
        vsync = (y != 5);
        if (x == 0 && y < V_LINES) begin
            t = (y == V_LINES - 1) ? 0 : y + 1;
            if (skip_trig) begin
                skip_trig  = 0;
                line_ok[t] = 0;
            end else begin
                for (int k = 0; k < H_PIX; k++) addr_q.push_back(FB_BASE + ADDR_W'(t * H_PIX + k));
                line_ok[t]     = 1;
                line_ok[t ^ 2] = 0;
            end
        end
        e.hs  = hsync;
        e.vs  = vsync;
        e.de  = de;
        e.chk = de && ((y < V_LINES) ? line_ok[y] : 1'b0);
        e.rgb = PIX_W'(32'h100 + 8 * y + x);
        exp_q.push_back(e);
    endtask

    // mode 0: always ready, 1: stall on x=3..5, 2: never ready
    task automatic run_line(input int y, input int mode);
        for (int x = 0; x < H_TOT; x++) begin
            tick(x, y);
            req_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(x >= 3 && x <= 5) : 1'b0;
        end
    endtask

    task automatic run_lines(input int first, input int last);
        for (int y = first; y <= last; y++) run_line(y, 0);
    endtask

    task automatic do_reset();
        @(posedge clk_pix);
        #1;
        mon_en    = 0;
        rst_pix_n = 1'b0;
        sx        = 12'(H_TOT - 1);
        sy        = 12'(V_TOT - 1);
        hsync     = 1'b1;
        vsync     = 1'b1;
        de        = 1'b0;
        req_ready = 1'b1;
        repeat (3) @(posedge clk_pix);
        #1;
        check("rst_underrun_stk", underrun_stk, 0);
        check("rst_underrun", underrun, 0);
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < V_LINES; i++) line_ok[i] = 0;
        rst_pix_n = 1'b1;
        mon_en    = 1;
    endtask

    // Memory: data equals address, answered one cycle after accept.
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk_pix);
            m_acc  = req_valid && req_ready && rst_pix_n;
            m_addr = req_addr;
            @(posedge clk_pix);
            #1;
            rsp_valid = m_acc && rst_pix_n;
            rsp_data  = PIX_W'(m_addr);
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pix);
            if (!mon_en) begin
                stall_prev = 0;
            end else begin
                if (exp_q.size() > 2) begin
                    e = exp_q.pop_front();
                    check("out_hsync", out_hsync, e.hs);
                    check("out_vsync", out_vsync, e.vs);
                    check("out_de", out_de, e.de);
                    if (e.chk) check("rgb_pixel", rgb, e.rgb);
                    else if (!e.de) check("rgb_blank", rgb, 0);
                end
                if (req_valid && req_ready) begin
                    n_acc++;
                    check("req_expected", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) check("req_addr", req_addr, addr_q.pop_front());
                end
                if (stall_prev && req_valid) check("addr_hold", req_addr, stall_addr);
                stall_prev = req_valid && !req_ready;
                stall_addr = req_addr;
                if (underrun) n_urun++;
            end
        end
    end

    initial begin
        int a0;
        int u0;
        for (int i = 0; i < V_LINES; i++) line_ok[i] = 0;
        rst_pix_n = 1'b0;
        sx        = 12'(H_TOT - 1);
        sy        = 12'(V_TOT - 1);
        hsync     = 1'b1;
        vsync     = 1'b1;
        de        = 1'b0;
        req_ready = 1'b1;
        repeat (3) @(posedge clk_pix);
        #1;
        check("reset_rgb", rgb, 0);
        check("reset_out_de", out_de, 0);
        check("reset_out_hsync", out_hsync, 1);
        check("reset_out_vsync", out_vsync, 1);
        check("reset_req_valid", req_valid, 0);
        check("reset_req_addr", req_addr, 0);
        check("reset_underrun", underrun, 0);
        check("reset_underrun_stk", underrun_stk, 0);
        rst_pix_n = 1'b1;
        mon_en    = 1;

        // First fetch after reset: line 1 at 0x108..0x10F, back-to-back.
        a0 = n_acc;
        for (int x = 0; x <= 10; x++) tick(x, 0);
        check("t1_accepts", n_acc - a0, 8);
        check("t1_req_valid_done", req_valid, 0);
        for (int x = 11; x < H_TOT; x++) tick(x, 0);
        run_lines(1, 3);

        // Blanking lines must not fetch.
        a0 = n_acc;
        run_lines(4, 5);
        check("t4_blank_accepts", n_acc - a0, 0);

        // Second frame: every line, including line 0, now valid.
        run_lines(0, 5);

        // Stalled request stream during line 1.
        run_line(0, 0);
        a0 = n_acc;
        run_line(1, 1);
        check("t3_stall_accepts", n_acc - a0, 8);
        run_lines(2, 5);

        // Memory blocked a whole line: underrun at the next trigger.
        run_line(0, 0);
        u0 = n_urun;
        run_line(1, 2);
        line_ok[2] = 0;
        skip_trig  = 1;
        run_lines(2, 5);
        check("t5_underrun_pulses", n_urun - u0, 1);
        check("t5_underrun_stk", underrun_stk, 1);
        run_lines(0, 5);
        check("t5_stk_still_set", underrun_stk, 1);
        check("t5_no_more_underrun", n_urun - u0, 1);
        check("addr_queue_drained", addr_q.size(), 0);

        do_reset();

        // Reset in the middle of a fetch, with i=3.
        run_line(0, 0);
        for (int x = 0; x <= 4; x++) tick(x, 1);
        check("t6_pre_req_valid", req_valid, 1);
        check("t6_pre_req_addr", req_addr, 32'h113);
        check("t6_pre_out_de", out_de, 1);
        #3;
        mon_en    = 0;
        rst_pix_n = 1'b0;
        #1;
        check("t6_req_valid", req_valid, 0);
        check("t6_req_addr", req_addr, 0);
        check("t6_out_hsync", out_hsync, 1);
        check("t6_out_de", out_de, 0);
        check("t6_rgb", rgb, 0);
        repeat (2) @(posedge clk_pix);
        #1;
        rst_pix_n = 1'b1;
        repeat (4) @(posedge clk_pix);
        #1;
        check("t6_idle_after_reset", req_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
